univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register with single-step operations and a
//            counted burst-shift engine (IDLE/RUN FSM).
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [2:0] c_m_hold = 3'b000;
    localparam logic [2:0] c_m_shr  = 3'b001;
    localparam logic [2:0] c_m_shl  = 3'b010;
    localparam logic [2:0] c_m_load = 3'b011;
    localparam logic [2:0] c_m_ror  = 3'b100;
    localparam logic [2:0] c_m_rol  = 3'b101;
    localparam logic [2:0] c_m_asr  = 3'b110;
    localparam logic [2:0] c_m_clr  = 3'b111;

    logic [0:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic             r_done, w_done_nxt;
    logic             w_is_shift;

    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             smsb,
        input logic             slsb
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (m)
            c_m_hold: res = cur;
            c_m_shr:  res = {smsb, cur[WIDTH-1:1]};
            c_m_shl:  res = {cur[WIDTH-2:0], slsb};
            c_m_load: res = ld;
            c_m_ror:  res = {cur[0], cur[WIDTH-1:1]};
            c_m_rol:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            c_m_asr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            c_m_clr:  res = '0;
            default:  res = cur;
        endcase
        return res;
    endfunction

    // Only the five shift/rotate modes may launch a burst; others fall back to a single step.
    assign w_is_shift = (mode == c_m_shr) || (mode == c_m_shl) || (mode == c_m_ror) ||
                        (mode == c_m_rol) || (mode == c_m_asr);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_st_run: begin
                w_q_nxt   = f_step(r_mode, r_q, d, sin_msb, sin_lsb);
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = c_st_idle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                if (start && w_is_shift) begin
                    w_mode_nxt = mode;
                    w_cnt_nxt  = amount;
                    if (amount != '0) begin
                        w_state_nxt = c_st_run;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else if (en) begin
                    w_q_nxt = f_step(mode, r_q, d, sin_msb, sin_lsb);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= c_m_hold;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];
    assign busy     = (r_state == c_st_run);
    assign done     = r_done;

endmodule
`default_nettype wire
